uart_rx_deframer: RTL

//  Receive-side framer of the UART: oversamples the asynchronous Rx line and recovers

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_deframer_if.sv | 27 ++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_rx_deframer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART types, error-flag indices and parity helper
// Rev 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5,
    BRK    = 3'd6
  } rx_state_t;

  localparam int ERR_BREAK  = 0;
  localparam int ERR_PARITY = 1;
  localparam int ERR_FRAME  = 2;

  // XOR of the low n bits; equals the even-parity bit the transmitter appends.
  function automatic logic even_parity(logic [7:0] d, int n);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) p = p ^ d[i];
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_deframer_if.sv
`default_nettype none
// ============================================================================
// uart_rx_deframer_if : serial line, flow control and FIFO push bundle
// Rev 1.0
// ============================================================================
interface uart_rx_deframer_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 Rx;
  logic                 FIFO_Full;
  logic                 RTS;
  logic [DATA_BITS-1:0] Data_Out;
  logic                 Data_Valid;
  logic [2:0]           Rx_Error;
  logic                 Overrun;

  modport master (
    input  Rx, FIFO_Full,
    output RTS, Data_Out, Data_Valid, Rx_Error, Overrun
  );

  modport slave (
    output Rx, FIFO_Full,
    input  RTS, Data_Out, Data_Valid, Rx_Error, Overrun
  );
endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// uart_baud_tick : free-running divider producing a one-cycle sample tick
// Rev 1.0
// ============================================================================
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic SysClk,
  input  logic Rst_n,
  input  logic i_restart,
  output logic o_tick
);
  localparam int c_w = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_w-1:0] c_last = c_w'(DIV - 1);

  logic [c_w-1:0] r_cnt;

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_w'(1);
    end
  end

  assign o_tick = (r_cnt == c_last);
endmodule
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// uart_rx_deframer : oversampling UART receiver, one FIFO push per frame
// Rev 1.0
// ============================================================================
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_BIT  = 1,
  parameter int STOP_BITS   = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic               SysClk,
  input  logic               Rst_n,
  uart_rx_deframer_if.master bus
);
  localparam int c_div  = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int c_osw  = $clog2(OVERSAMPLE);
  localparam int c_bmax = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int c_bcw  = $clog2(c_bmax + 1);
  localparam logic [c_osw-1:0] c_os_s0   = c_osw'(OVERSAMPLE / 2 - 1);
  localparam logic [c_osw-1:0] c_os_s1   = c_osw'(OVERSAMPLE / 2);
  localparam logic [c_osw-1:0] c_os_s2   = c_osw'(OVERSAMPLE / 2 + 1);
  localparam logic [c_osw-1:0] c_os_last = c_osw'(OVERSAMPLE - 1);
  localparam logic [c_bcw-1:0] c_data_last = c_bcw'(DATA_BITS - 1);
  localparam logic [c_bcw-1:0] c_stop_last = c_bcw'(STOP_BITS - 1);

  rx_state_t            r_state;
  logic [1:0]           r_sync;
  logic                 r_rx_prev;
  logic [c_osw-1:0]     r_os_cnt;
  logic [c_bcw-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_s0, r_s1, r_par_bit, r_nonzero, r_frame_err;
  logic                 r_rts, r_data_valid, r_overrun;
  logic [DATA_BITS-1:0] r_data_out;
  logic [2:0]           r_rx_error;

  logic       w_rx, w_fall, w_restart, w_tick, w_vote, w_mid, w_end;
  logic       w_brk, w_par_err;
  logic [2:0] w_err;

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], bus.Rx};
      r_rx_prev <= r_sync[1];
    end
  end

  assign w_rx      = r_sync[1];
  assign w_fall    = r_rx_prev & ~w_rx;
  assign w_restart = (r_state == IDLE) && w_fall;

  uart_baud_tick #(.DIV(c_div)) u_tick (
    .SysClk    (SysClk),
    .Rst_n     (Rst_n),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // The third sample is the live synchronised value at the vote tick.
  assign w_vote = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_mid  = w_tick && (r_os_cnt == c_os_s2);
  assign w_end  = w_tick && (r_os_cnt == c_os_last);

  assign w_brk     = ~(r_nonzero | w_vote);
  assign w_par_err = (PARITY_BIT != 0) && (even_parity(8'(r_shift), DATA_BITS) != r_par_bit);

  always_comb begin
    w_err = 3'b000;
    if (w_brk) begin
      w_err[ERR_BREAK] = 1'b1;
    end else begin
      w_err[ERR_PARITY] = w_par_err;
      w_err[ERR_FRAME]  = r_frame_err | ~w_vote;
    end
  end

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= IDLE;
      r_os_cnt     <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_s0         <= 1'b0;
      r_s1         <= 1'b0;
      r_par_bit    <= 1'b0;
      r_nonzero    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_rts        <= 1'b0;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_data_out   <= '0;
      r_rx_error   <= 3'b000;
    end else begin
      r_rts        <= ~bus.FIFO_Full;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
      if (w_tick) begin
        if (r_os_cnt == c_os_s0) r_s0 <= w_rx;
        if (r_os_cnt == c_os_s1) r_s1 <= w_rx;
        r_os_cnt <= (r_os_cnt == c_os_last) ? '0 : r_os_cnt + c_osw'(1);
      end
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state     <= START;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_nonzero   <= 1'b0;
            r_frame_err <= 1'b0;
          end
        end
        START: begin
          if (w_mid && w_vote)  r_state <= IDLE;
          else if (w_end)       r_state <= DATA;
        end
        DATA: begin
          if (w_mid) begin
            r_shift   <= (r_shift << 1) | DATA_BITS'(w_vote);
            r_nonzero <= r_nonzero | w_vote;
          end
          if (w_end) begin
            if (r_bit_cnt == c_data_last) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY_BIT != 0) ? PARITY : STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + c_bcw'(1);
            end
          end
        end
        PARITY: begin
          if (w_mid) begin
            r_par_bit <= w_vote;
            r_nonzero <= r_nonzero | w_vote;
          end
          if (w_end) r_state <= STOP;
        end
        STOP: begin
          if (w_mid && (r_bit_cnt == c_stop_last)) begin
            // Frame decided at the last stop-bit centre; push lands next cycle.
            r_state  <= w_brk ? BRK : DONE;
            r_os_cnt <= '0;
            if (bus.FIFO_Full) begin
              r_overrun <= 1'b1;
            end else begin
              r_data_valid <= 1'b1;
              r_data_out   <= w_brk ? '0 : r_shift;
              r_rx_error   <= w_err;
            end
          end else if (w_mid) begin
            r_frame_err <= r_frame_err | ~w_vote;
            r_nonzero   <= r_nonzero | w_vote;
          end else if (w_end) begin
            r_bit_cnt <= r_bit_cnt + c_bcw'(1);
          end
        end
        DONE: r_state <= IDLE;
        BRK: begin
          // Leave only after a full bit time of continuous idle-high line.
          if (!w_rx)      r_os_cnt <= '0;
          else if (w_end) r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.RTS        = r_rts;
  assign bus.Data_Out   = r_data_out;
  assign bus.Data_Valid = r_data_valid;
  assign bus.Rx_Error   = r_rx_error;
  assign bus.Overrun    = r_overrun;
endmodule
`default_nettype wire
